// File: rtl/telegraph_keyer.sv
`default_nettype none
// ============================================================================
// Module      : telegraph_keyer
// Description : Keys the telegraph line for one dot, dash or gap symbol per
//               handshake, timing each unit in TickEn strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module telegraph_keyer #(
   parameter int UNIT_TICKS = 8
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       TickEn,
   input  logic [1:0] SymIn,
   input  logic       SymValid,
   output logic       SymReady,
   output logic       Line,
   output logic       Busy,
   output logic       Done
);

   localparam int              c_tickW    = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
   localparam logic [c_tickW-1:0] c_lastTick = c_tickW'(UNIT_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2
   } state_t;

   state_t             r_state, w_nextState;
   logic [c_tickW-1:0] r_tickCnt, w_nextTick;
   logic [2:0]         r_unitCnt, w_nextUnit;
   logic [1:0]         r_sym, w_nextSym;
   logic               r_line, w_nextLine;
   logic               r_done, w_nextDone;
   logic [2:0]         w_markUnits, w_spaceUnits, w_lastUnit;
   logic               w_accept, w_unitEnd;

   assign SymReady  = (r_state == IDLE) & ~Rst;
   assign w_accept  = SymReady & SymValid;
   assign w_unitEnd = TickEn & (r_tickCnt == c_lastTick);

   // Marks carry their own trailing 1-unit space; gaps add only the remainder.
   always_comb begin
      w_markUnits  = 3'd0;
      w_spaceUnits = 3'd0;
      case (r_sym)
         2'b00:   begin w_markUnits = 3'd1; w_spaceUnits = 3'd1; end
         2'b01:   begin w_markUnits = 3'd3; w_spaceUnits = 3'd1; end
         2'b10:   begin w_markUnits = 3'd0; w_spaceUnits = 3'd2; end
         default: begin w_markUnits = 3'd0; w_spaceUnits = 3'd6; end
      endcase
      w_lastUnit = ((r_state == MARK) ? w_markUnits : w_spaceUnits) - 3'd1;
   end

   always_comb begin
      w_nextState = r_state;
      w_nextTick  = r_tickCnt;
      w_nextUnit  = r_unitCnt;
      w_nextSym   = r_sym;
      w_nextDone  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextSym   = SymIn;
               w_nextTick  = '0;
               w_nextUnit  = 3'd0;
               w_nextState = SymIn[1] ? SPACE : MARK;
            end
         end
         MARK, SPACE: begin
            if (TickEn) begin
               if (w_unitEnd) begin
                  w_nextTick = '0;
                  if (r_unitCnt == w_lastUnit) begin
                     w_nextUnit = 3'd0;
                     if (r_state == MARK) begin
                        w_nextState = SPACE;
                     end else begin
                        w_nextState = IDLE;
                        w_nextDone  = 1'b1;
                     end
                  end else begin
                     w_nextUnit = r_unitCnt + 3'd1;
                  end
               end else begin
                  w_nextTick = r_tickCnt + c_tickW'(1);
               end
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextTick  = '0;
            w_nextUnit  = 3'd0;
         end
      endcase
      w_nextLine = (w_nextState == MARK);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= IDLE;
         r_tickCnt <= '0;
         r_unitCnt <= 3'd0;
         r_sym     <= 2'b00;
         r_line    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_tickCnt <= w_nextTick;
         r_unitCnt <= w_nextUnit;
         r_sym     <= w_nextSym;
         r_line    <= w_nextLine;
         r_done    <= w_nextDone;
      end
   end

   assign Line = r_line;
   assign Done = r_done;
   assign Busy = (r_state != IDLE);

endmodule
`default_nettype wire
